// File: rtl/cpu_0_jtag_debug_host.sv
// cpu_0_jtag_debug_host: on-chip virtual-JTAG initiator that runs one IR+DR scan per command
// and returns the captured tdo word and ir_out to system logic.
module cpu_0_jtag_debug_host #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  input  logic [1:0]          vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int DW = $clog2(2 * TCK_DIV);
  localparam int CW = $clog2(DR_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, DONE} state_t;
  state_t st, nxt;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [DR_WIDTH-1:0] sr;
  logic tdi, scanning, tp_end, sample, last_bit;
  assign scanning = st inside {UIR, CDR, SDR, UDR};
  assign tp_end   = div == DW'(2 * TCK_DIV - 1);
  assign sample   = div == DW'(TCK_DIV - 1);
  assign last_bit = cnt == CW'(DR_WIDTH - 1);
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = cmd_valid ? UIR : IDLE;
      UIR:     nxt = tp_end ? CDR : UIR;
      CDR:     nxt = tp_end ? SDR : CDR;
      SDR:     nxt = (tp_end && last_bit) ? UDR : SDR;
      UDR:     nxt = tp_end ? DONE : UDR;
      default: nxt = IDLE;
    endcase
  end
  // tdi is re-registered only at TP boundaries so it never moves while tck is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      div       <= '0;
      cnt       <= '0;
      sr        <= '0;
      tdi       <= 1'b0;
      rsp_data  <= '0;
      rsp_ir    <= 2'd0;
      vji_ir_in <= 2'd0;
    end else begin
      st  <= nxt;
      div <= (!scanning || tp_end) ? '0 : div + DW'(1);
      cnt <= (st == SDR && tp_end) ? cnt + CW'(1) : (st == SDR ? cnt : '0);
      if (st == IDLE && cmd_valid) begin
        vji_ir_in <= cmd_ir;
        sr        <= cmd_data;
      end
      if (st == UIR && sample) rsp_ir <= vji_ir_out;
      if (st == SDR && sample) sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
      if (tp_end) tdi <= (nxt == SDR) ? sr[0] : 1'b0;
      if (st == UDR && tp_end) rsp_data <= sr;
    end
  end
  assign cmd_ready = st == IDLE;
  assign rsp_valid = st == DONE;
  assign vji_tck   = scanning && div >= DW'(TCK_DIV);
  assign vji_tdi   = tdi;
  assign vji_uir   = st == UIR;
  assign vji_cdr   = st == CDR;
  assign vji_sdr   = st == SDR;
  assign vji_udr   = st == UDR;
  assign vji_rti   = st == IDLE || st == DONE;
endmodule

// File: tb/tb_cpu_0_jtag_debug_host.sv
// tb_cpu_0_jtag_debug_host: directed scans checked against a timeline model of the JTAG host.
module tb_cpu_0_jtag_debug_host;
  localparam int DR  = 38;
  localparam int TD  = 2;
  localparam int TP  = 2 * TD;
  localparam int FIN = (DR + 3) * TP;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_ir = 2'd0;
  logic [DR-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  logic vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [DR-1:0] rsp_data;
  logic [1:0] rsp_ir, vji_ir_in, vji_ir_out;
  logic [1:0] ir_out_drv = 2'd0;
  int mode = 0;
  assign vji_tdo = (mode == 0) ? vji_tdi : (mode == 1);
  assign vji_ir_out = ir_out_drv;
  cpu_0_jtag_debug_host #(.DR_WIDTH(DR), .TCK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ir(rsp_ir), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti));
  logic c2_valid = 1'b0;
  logic [1:0] c2_ir = 2'd0;
  logic [7:0] c2_data = 8'd0;
  logic c2_ready, c2_rsp_valid, c2_tck, c2_tdi, c2_uir, c2_cdr, c2_sdr, c2_udr, c2_rti;
  logic [7:0] c2_rsp_data;
  logic [1:0] c2_rsp_ir, c2_ir_in;
  cpu_0_jtag_debug_host #(.DR_WIDTH(8), .TCK_DIV(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_ir(c2_ir), .cmd_data(c2_data), .rsp_valid(c2_rsp_valid), .rsp_data(c2_rsp_data),
    .rsp_ir(c2_rsp_ir), .vji_tck(c2_tck), .vji_tdi(c2_tdi), .vji_tdo(c2_tdi),
    .vji_ir_in(c2_ir_in), .vji_ir_out(2'b10), .vji_uir(c2_uir), .vji_cdr(c2_cdr),
    .vji_sdr(c2_sdr), .vji_udr(c2_udr), .vji_rti(c2_rti));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a scan is a timeline of k clocks after accept; TP-long segments UIR,CDR,SDR*DR,UDR then DONE
  logic busy;
  int k;
  logic [DR-1:0] m_data, exp_data, m_rsp_data;
  logic [1:0] m_ir_in, m_rsp_ir;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      k <= 0;
      m_data <= '0;
      exp_data <= '0;
      m_rsp_data <= '0;
      m_ir_in <= 2'd0;
      m_rsp_ir <= 2'd0;
    end else if (busy) begin
      if (k == FIN) busy <= 1'b0;
      else k <= k + 1;
      if (k == TD - 1) m_rsp_ir <= ir_out_drv;
      if (k == FIN - 1) m_rsp_data <= exp_data;
    end else if (cmd_valid) begin
      busy <= 1'b1;
      k <= 0;
      m_ir_in <= cmd_ir;
      m_data <= cmd_data;
      exp_data <= (mode == 0) ? cmd_data : (mode == 1 ? '1 : '0);
    end
  end
  int seg, ph, n_rsp = 0, c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, c2_nsdr = 0;
  logic act, e_sdr;
  logic [12:0] e_o, a_o;
  logic [DR-1:0] rlog [8];
  always @(negedge clk) begin
    act = busy && k < FIN;
    seg = k / TP;
    ph = k % TP;
    e_sdr = act && seg >= 2 && seg < DR + 2;
    e_o = {!busy, busy && k == FIN, act && ph >= TD, e_sdr ? m_data[e_sdr ? seg - 2 : 0] : 1'b0,
           act && seg == 0, act && seg == 1, e_sdr, act && seg == DR + 2, !act, m_ir_in, m_rsp_ir};
    a_o = {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
           vji_ir_in, rsp_ir};
    chk("outputs", 64'(a_o), 64'(e_o));
    chk("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    c_uir += int'(vji_uir);
    c_cdr += int'(vji_cdr);
    c_sdr += int'(vji_sdr);
    c_udr += int'(vji_udr);
    c2_nsdr += int'(c2_sdr);
    if (rsp_valid) begin
      rlog[n_rsp % 8] <= rsp_data;
      n_rsp <= n_rsp + 1;
    end
  end
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask
  task automatic run_cmd(input logic [1:0] ir, input logic [DR-1:0] d, output int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir = ir;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ir = ~ir;
    cmd_data = ~d;
    wait_rsp(n);
    @(negedge clk);
  endtask
  task automatic clr_counts();
    @(posedge clk);
    #1;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c2_nsdr = 0;
  endtask
  localparam logic [DR-1:0] PA = 38'h2A_5A5A_5A5A;
  localparam logic [DR-1:0] PB = 38'h15_0F0F_1234;
  localparam logic [DR-1:0] PC = 38'h3F_FFFF_0001;
  int lat, n0;
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
        vji_udr, vji_rti, vji_ir_in, rsp_ir, rsp_data}), 64'({9'b100000001, 2'd0, 2'd0, 38'd0}));
    reset_n = 1'b1;
    mode = 0;
    ir_out_drv = 2'b01;
    clr_counts();
    run_cmd(2'd2, PA, lat);
    chk("loop_latency", 64'(lat), 64'd165);
    chk("loop_data", 64'(rsp_data), 64'(PA));
    chk("loop_ir_in", 64'(vji_ir_in), 64'd2);
    chk("loop_rsp_ir", 64'(rsp_ir), 64'd1);
    mode = 1;
    ir_out_drv = 2'b11;
    clr_counts();
    run_cmd(2'd1, PB, lat);
    chk("ones_data", 64'(rsp_data), 64'h3F_FFFF_FFFF);
    chk("ones_rsp_ir", 64'(rsp_ir), 64'd3);
    chk("uir_clks", 64'(c_uir), 64'd4);
    chk("cdr_clks", 64'(c_cdr), 64'd4);
    chk("sdr_clks", 64'(c_sdr), 64'd152);
    chk("udr_clks", 64'(c_udr), 64'd4);
    mode = 2;
    ir_out_drv = 2'b10;
    run_cmd(2'd3, PC, lat);
    chk("zeros_data", 64'(rsp_data), 64'd0);
    chk("zeros_rsp_ir", 64'(rsp_ir), 64'd2);
    mode = 0;
    n0 = n_rsp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = PC;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = PB;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (200) @(negedge clk);
    chk("busy_rsp_count", 64'(n_rsp - n0), 64'd1);
    chk("busy_data", 64'(rlog[n0 % 8]), 64'(PC));
    n0 = n_rsp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir = 2'd1;
    cmd_data = PA;
    @(negedge clk);
    cmd_ir = 2'd2;
    cmd_data = PB;
    wait_rsp(lat);
    chk("b2b_lat_a", 64'(lat), 64'd165);
    @(negedge clk);
    chk("b2b_ready_gap", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("b2b_accept_b", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("b2b_lat_b", 64'(lat), 64'd165);
    repeat (2) @(negedge clk);
    chk("b2b_order_a", 64'(rlog[n0 % 8]), 64'(PA));
    chk("b2b_order_b", 64'(rlog[(n0 + 1) % 8]), 64'(PB));
    chk("b2b_ir_in", 64'(vji_ir_in), 64'd2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir = 2'd3;
    cmd_data = PC;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (59) @(negedge clk);
    n0 = n_rsp;
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_out", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
        vji_udr, vji_rti, vji_ir_in, rsp_ir, rsp_data}), 64'({9'b100000001, 2'd0, 2'd0, 38'd0}));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("midreset_no_rsp", 64'(n_rsp - n0), 64'd0);
    ir_out_drv = 2'b01;
    run_cmd(2'd1, PB, lat);
    chk("post_reset_lat", 64'(lat), 64'd165);
    chk("post_reset_data", 64'(rsp_data), 64'(PB));
    clr_counts();
    @(negedge clk);
    c2_valid = 1'b1;
    c2_ir = 2'd3;
    c2_data = 8'hB4;
    @(negedge clk);
    c2_valid = 1'b0;
    c2_data = 8'h00;
    lat = 1;
    while (!c2_rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("div1_latency", 64'(lat), 64'd23);
    @(negedge clk);
    chk("div1_data", 64'(c2_rsp_data), 64'hB4);
    chk("div1_rsp_ir", 64'(c2_rsp_ir), 64'd2);
    chk("div1_ir_in", 64'(c2_ir_in), 64'd3);
    chk("div1_sdr_clks", 64'(c2_nsdr), 64'd16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
